// File: rtl/mcse_ipid_pkg.sv
// Shared types and constants for the IP ID frame sequencer.
package mcse_ipid_pkg;

   // Default geometry of one IP ID: 16 words of 16 bits.
   localparam int unsigned DEF_WORD_W       = 16;
   localparam int unsigned DEF_WORDS_PER_ID = 16;
   localparam int unsigned IPID_W           = DEF_WORD_W * DEF_WORDS_PER_ID;

   // Frame delimiters used by the host on the GPIO word bus.
   localparam logic [DEF_WORD_W-1:0] HDR_WORD_DEF = 16'h7A7A;
   localparam logic [DEF_WORD_W-1:0] TRL_WORD_DEF = 16'hB9B9;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_HDR = 3'd1,
      ST_DATA     = 3'd2,
      ST_TRAIL    = 3'd3,
      ST_RELEASE  = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERR      = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_FRAME   = 2'b10,
      ERR_DROP    = 2'b11
   } err_code_e;

   // A collection run is in progress in every state that talks to the host.
   function automatic logic is_busy(input state_e s);
      return (s == ST_WAIT_HDR) || (s == ST_DATA) || (s == ST_TRAIL) || (s == ST_RELEASE);
   endfunction

   // The trigger stays up from the header wait until the trailer is accepted.
   function automatic logic is_trig(input state_e s);
      return (s == ST_WAIT_HDR) || (s == ST_DATA) || (s == ST_TRAIL);
   endfunction

endpackage

// File: rtl/ipid_word_assembler.sv
// Shifts host words MSB-first into one ID and counts words so the
// sequencer knows when the final word of an ID is being taken.
module ipid_word_assembler #(
   parameter int unsigned WORD_W       = 16,
   parameter int unsigned WORDS_PER_ID = 16,
   localparam int unsigned ID_W  = WORD_W * WORDS_PER_ID,
   localparam int unsigned CNT_W = (WORDS_PER_ID > 1) ? $clog2(WORDS_PER_ID) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   output logic [ID_W-1:0]   data_o,
   output logic              last_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_ID - 1);

   logic [ID_W-1:0]  data_q, data_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;

   assign data_o = data_q;
   assign last_o = (cnt_q == LAST_CNT);

   // Next-state for the shift register and word counter.
   always_comb begin
      // NOTE: every _d gets a default first so no path can leave it unassigned and infer a latch.
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         // Only the counter restarts; the last ID stays readable until new words arrive.
         cnt_d = '0;
      end else if (load_i) begin
         data_d = {data_q[ID_W-WORD_W-1:0], word_i};
         cnt_d  = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Register the assembled ID and the word count.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: this is a plain register, not a RAM, so it is reset to give a defined id_data_o of 0.
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments only in clocked blocks so all flops update from pre-edge values.
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/ipid_frame_sequencer.sv
// Secure-boot side collector of the IP IDs. For each index it raises the
// trigger, receives a header/data/trailer burst from the host, and writes
// the assembled ID to the IP ID register file. Frame errors and host
// silence end the run in a sticky error state instead of hanging.
module ipid_frame_sequencer
   import mcse_ipid_pkg::*;
#(
   parameter int unsigned       NUM_IPS        = 16,
   parameter int unsigned       WORD_W         = DEF_WORD_W,
   parameter int unsigned       WORDS_PER_ID   = DEF_WORDS_PER_ID,
   parameter logic [WORD_W-1:0] HDR_WORD       = WORD_W'(HDR_WORD_DEF),
   parameter logic [WORD_W-1:0] TRL_WORD       = WORD_W'(TRL_WORD_DEF),
   parameter int unsigned       TIMEOUT_CYCLES = 1024,
   localparam int unsigned IDX_W = (NUM_IPS > 1) ? $clog2(NUM_IPS) : 1,
   localparam int unsigned ID_W  = WORD_W * WORDS_PER_ID
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [WORD_W-1:0] gpio_data_i,
   input  logic              gpio_valid_i,
   output logic              trig_o,
   output logic [IDX_W-1:0]  addr_o,
   output logic              id_we_o,
   output logic [IDX_W-1:0]  id_idx_o,
   output logic [ID_W-1:0]   id_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [1:0]        err_code_o
);

   localparam int unsigned      TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TMO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IPS - 1);

   // FSM state and bookkeeping.
   state_e           state_q,    state_d;
   logic [IDX_W-1:0] index_q,    index_d;
   logic [TO_W-1:0]  tmo_q,      tmo_d;
   logic             rel_low_q,  rel_low_d;
   err_code_e        err_code_q, err_code_d;

   // Registered outputs.
   logic             trig_q,   trig_d;
   logic             id_we_q,  id_we_d;
   logic [IDX_W-1:0] id_idx_q, id_idx_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             error_q,  error_d;

   // Assembler controls.
   logic asm_clr;
   logic asm_load;
   logic asm_last;

   ipid_word_assembler #(
      .WORD_W       (WORD_W),
      .WORDS_PER_ID (WORDS_PER_ID)
   ) u_asm (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (asm_clr),
      .load_i (asm_load),
      .word_i (gpio_data_i),
      .data_o (id_data_o),
      .last_o (asm_last)
   );

   // Frame-protocol decisions: next state, counters and output values.
   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      tmo_d      = tmo_q;
      rel_low_d  = rel_low_q;
      err_code_d = err_code_q;
      id_we_d    = 1'b0;
      id_idx_d   = id_idx_q;
      asm_clr    = 1'b0;
      asm_load   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_i) begin
               state_d    = ST_WAIT_HDR;
               index_d    = '0;
               tmo_d      = '0;
               err_code_d = ERR_NONE;
               asm_clr    = 1'b1;
            end
         end

         ST_WAIT_HDR: begin
            tmo_d = tmo_q + 1'b1;
            if (gpio_valid_i) begin
               if (gpio_data_i == HDR_WORD) begin
                  state_d = ST_DATA;
               end else begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_FRAME;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d    = ST_ERR;
               err_code_d = ERR_TIMEOUT;
            end
         end

         ST_DATA: begin
            if (gpio_valid_i) begin
               asm_load = 1'b1;
               if (asm_last) begin
                  state_d = ST_TRAIL;
               end
            end else begin
               state_d    = ST_ERR;
               err_code_d = ERR_DROP;
            end
         end

         ST_TRAIL: begin
            if (!gpio_valid_i) begin
               state_d    = ST_ERR;
               err_code_d = ERR_DROP;
            end else if (gpio_data_i == TRL_WORD) begin
               id_we_d   = 1'b1;
               id_idx_d  = index_q;
               rel_low_d = 1'b0;
               state_d   = ST_RELEASE;
            end else begin
               state_d    = ST_ERR;
               err_code_d = ERR_FRAME;
            end
         end

         ST_RELEASE: begin
            // First wait for the host to drop valid, then spend one idle cycle.
            if (rel_low_q) begin
               if (index_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  index_d = index_q + 1'b1;
                  tmo_d   = '0;
                  state_d = ST_WAIT_HDR;
               end
            end else if (!gpio_valid_i) begin
               rel_low_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Level outputs follow the state being entered so they are registered.
      trig_d  = is_trig(state_d);
      busy_d  = is_busy(state_d);
      done_d  = (state_d == ST_DONE);
      error_d = (state_d == ST_ERR);
   end

   // Single state register for the FSM, its counters and its outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         index_q    <= '0;
         tmo_q      <= '0;
         rel_low_q  <= 1'b0;
         err_code_q <= ERR_NONE;
         trig_q     <= 1'b0;
         id_we_q    <= 1'b0;
         id_idx_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         tmo_q      <= tmo_d;
         rel_low_q  <= rel_low_d;
         err_code_q <= err_code_d;
         trig_q     <= trig_d;
         id_we_q    <= id_we_d;
         id_idx_q   <= id_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign trig_o     = trig_q;
   assign addr_o     = index_q;
   assign id_we_o    = id_we_q;
   assign id_idx_o   = id_idx_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign err_code_o = err_code_q;

endmodule

// File: tb/tb_ipid_frame_sequencer.sv
// Bench for ipid_frame_sequencer: a host model drives framed bursts,
// expected writes go into a queue and are popped when id_we_o fires.
module tb_ipid_frame_sequencer;

   localparam int unsigned ID_W    = 256;
   localparam logic [15:0] HDR     = 16'h7A7A;
   localparam logic [15:0] TRL     = 16'hB9B9;
   localparam int          LATENCY = 18;

   typedef logic [ID_W-1:0] v_t;
   typedef struct packed {
      logic [3:0]      idx;
      logic [ID_W-1:0] data;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            start_i;
   logic [15:0]     gpio_data_i;
   logic            gpio_valid_i;
   logic            trig_o;
   logic [3:0]      addr_o;
   logic            id_we_o;
   logic [3:0]      id_idx_o;
   logic [ID_W-1:0] id_data_o;
   logic            busy_o;
   logic            done_o;
   logic            error_o;
   logic [1:0]      err_code_o;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_writes = 0;
   int   cyc      = 0;
   int   hdr_cyc  = 0;
   exp_t exp_q[$];
   v_t   got_id[16];

   ipid_frame_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .gpio_data_i  (gpio_data_i),
      .gpio_valid_i (gpio_valid_i),
      .trig_o       (trig_o),
      .addr_o       (addr_o),
      .id_we_o      (id_we_o),
      .id_idx_o     (id_idx_o),
      .id_data_o    (id_data_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .err_code_o   (err_code_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input v_t got, input v_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_trig"},     v_t'(trig_o),     v_t'(0));
      check({pfx, "_addr"},     v_t'(addr_o),     v_t'(0));
      check({pfx, "_we"},       v_t'(id_we_o),    v_t'(0));
      check({pfx, "_idx"},      v_t'(id_idx_o),   v_t'(0));
      check({pfx, "_data"},     id_data_o,        v_t'(0));
      check({pfx, "_busy"},     v_t'(busy_o),     v_t'(0));
      check({pfx, "_done"},     v_t'(done_o),     v_t'(0));
      check({pfx, "_error"},    v_t'(error_o),    v_t'(0));
      check({pfx, "_err_code"}, v_t'(err_code_o), v_t'(0));
   endtask

   // Start pulse; returns on the negedge after the DUT has taken it.
   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Host model for one IP. w0 < 0 means a random first data word.
   // n_words < 16 drops valid after that many data words.
   task automatic run_frame(input int ip, input logic [15:0] hdr, input logic [15:0] trl,
                            input int n_words, input int w0, input bit poke);
      v_t          id;
      logic [15:0] w;
      bit          ok;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (trig_o && (addr_o == 4'(ip))) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("trig_wait", v_t'(trig_o), v_t'(1));
         return;
      end
      if (poke) begin
         pulse_start();
         check("busy_start_addr", v_t'(addr_o), v_t'(ip));
         check("busy_start_trig", v_t'(trig_o), v_t'(1));
      end
      gpio_valid_i = 1'b1;
      gpio_data_i  = hdr;
      hdr_cyc      = cyc;
      @(negedge clk);
      if (hdr != HDR) begin
         gpio_valid_i = 1'b0;
         return;
      end
      id = '0;
      for (int i = 0; i < n_words; i++) begin
         w = (i == 0 && w0 >= 0) ? w0[15:0] : 16'($urandom);
         id = {id[ID_W-17:0], w};
         gpio_data_i = w;
         @(negedge clk);
      end
      if (n_words < 16) begin
         gpio_valid_i = 1'b0;
         return;
      end
      gpio_data_i = trl;
      if (trl == TRL) exp_q.push_back('{idx: 4'(ip), data: id});
      @(negedge clk);
      gpio_valid_i = 1'b0;
      gpio_data_i  = '0;
   endtask

   task automatic wait_end();
      for (int i = 0; i < 64; i++) begin
         if (done_o || error_o) return;
         @(negedge clk);
      end
      check("end_wait", v_t'(done_o | error_o), v_t'(1));
   endtask

   // Write monitor: pops the scoreboard on every id_we_o.
   initial begin
      exp_t e;
      bit   prev_we;
      prev_we = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_we) check("we_pulse_width", v_t'(id_we_o), v_t'(0));
         prev_we = id_we_o;
         if (id_we_o === 1'b1) begin
            n_writes++;
            got_id[id_idx_o] = id_data_o;
            if (exp_q.size() == 0) begin
               check("we_unexpected", v_t'(id_we_o), v_t'(0));
            end else begin
               e = exp_q.pop_front();
               check("we_idx",     v_t'(id_idx_o),      v_t'(e.idx));
               check("we_data",    id_data_o,           e.data);
               check("we_latency", v_t'(cyc - hdr_cyc), v_t'(LATENCY));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w_base;
      int n;
      bit addr_ok;

      rst = 1'b1;
      start_i = 1'b0;
      gpio_data_i = '0;
      gpio_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Nominal run, with a start pulse injected while busy on IP 1.
      w_base = n_writes;
      pulse_start();
      check("nom_busy", v_t'(busy_o), v_t'(1));
      for (int ip = 0; ip < 16; ip++)
         run_frame(ip, HDR, TRL, 16, (ip == 3) ? 32'h1234 : -1, ip == 1);
      wait_end();
      repeat (2) @(negedge clk);
      check("nom_done",    v_t'(done_o),            v_t'(1));
      check("nom_error",   v_t'(error_o),           v_t'(0));
      check("nom_busy_end",v_t'(busy_o),            v_t'(0));
      check("nom_trig_end",v_t'(trig_o),            v_t'(0));
      check("nom_writes",  v_t'(n_writes - w_base), v_t'(16));
      check("nom_queue",   v_t'(exp_q.size()),      v_t'(0));
      check("nom_id3_msw", v_t'(got_id[3][255:240]),v_t'(16'h1234));

      // Bad header on IP 0.
      w_base = n_writes;
      pulse_start();
      check("restart_done_clr", v_t'(done_o), v_t'(0));
      run_frame(0, 16'h7A7B, TRL, 16, -1, 1'b0);
      check("badhdr_error", v_t'(error_o),    v_t'(1));
      check("badhdr_code",  v_t'(err_code_o), v_t'(2'b10));
      check("badhdr_trig",  v_t'(trig_o),     v_t'(0));
      check("badhdr_busy",  v_t'(busy_o),     v_t'(0));
      repeat (3) @(negedge clk);
      check("badhdr_writes", v_t'(n_writes - w_base), v_t'(0));

      // Bad trailer on IP 5.
      w_base = n_writes;
      pulse_start();
      check("restart_err_clr",  v_t'(error_o),    v_t'(0));
      check("restart_code_clr", v_t'(err_code_o), v_t'(0));
      for (int ip = 0; ip < 6; ip++)
         run_frame(ip, HDR, (ip == 5) ? 16'hB9B8 : TRL, 16, -1, 1'b0);
      check("badtrl_error", v_t'(error_o),    v_t'(1));
      check("badtrl_code",  v_t'(err_code_o), v_t'(2'b10));
      repeat (3) @(negedge clk);
      check("badtrl_writes", v_t'(n_writes - w_base), v_t'(5));
      check("badtrl_queue",  v_t'(exp_q.size()),      v_t'(0));

      // Valid dropped after data word 7 of IP 2.
      pulse_start();
      for (int ip = 0; ip < 3; ip++)
         run_frame(ip, HDR, TRL, (ip == 2) ? 8 : 16, -1, 1'b0);
      @(negedge clk);
      check("drop_error", v_t'(error_o),    v_t'(1));
      check("drop_code",  v_t'(err_code_o), v_t'(2'b11));
      check("drop_busy",  v_t'(busy_o),     v_t'(0));

      // Host silent: trigger held for the full timeout window.
      pulse_start();
      n = 0;
      addr_ok = 1'b1;
      while (n < 1100 && trig_o && !error_o) begin
         if (addr_o != 4'd0) addr_ok = 1'b0;
         n++;
         @(negedge clk);
      end
      check("tmo_trig_cycles", v_t'(n),          v_t'(1024));
      check("tmo_addr",        v_t'(addr_ok),    v_t'(1));
      check("tmo_error",       v_t'(error_o),    v_t'(1));
      check("tmo_code",        v_t'(err_code_o), v_t'(2'b01));
      check("tmo_trig_off",    v_t'(trig_o),     v_t'(0));

      // Reset in the middle of IP 7 data, then a complete fresh run.
      pulse_start();
      for (int ip = 0; ip < 8; ip++)
         run_frame(ip, HDR, TRL, (ip == 7) ? 5 : 16, -1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_queue", v_t'(exp_q.size()), v_t'(0));
      @(negedge clk);
      w_base = n_writes;
      pulse_start();
      for (int ip = 0; ip < 16; ip++)
         run_frame(ip, HDR, TRL, 16, -1, 1'b0);
      wait_end();
      repeat (2) @(negedge clk);
      check("rerun_done",   v_t'(done_o),            v_t'(1));
      check("rerun_error",  v_t'(error_o),           v_t'(0));
      check("rerun_writes", v_t'(n_writes - w_base), v_t'(16));
      check("rerun_queue",  v_t'(exp_q.size()),      v_t'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
